// File: rtl/maze_pkg.sv
// Shared dimensions, types and helpers for the 15x15 maze solver.
package maze_pkg;

  localparam int MAZE_W     = 15;
  localparam int MAZE_H     = 15;
  localparam int MAZE_CELLS = MAZE_W * MAZE_H;

  typedef logic [3:0] coord_t;
  typedef logic [1:0] label_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLOOD,
    TRACE,
    FAIL
  } maze_state_e;

  function automatic logic [7:0] cell_idx(input coord_t x, input coord_t y);
    return 8'(y) * 8'(MAZE_W) + 8'(x);
  endfunction

  function automatic label_t label_prev(input label_t l);
    return (l == 2'd0) ? 2'd2 : l - 2'd1;
  endfunction

endpackage

// File: rtl/maze_wave_step.sv
// One BFS wavefront step over the whole grid: marks open unvisited cells
// touching a visited cell (or just the goal on the seed wave) and relabels them.
module maze_wave_step
  import maze_pkg::*;
(
  input  logic [MAZE_CELLS-1:0]         i_grid,
  input  logic [MAZE_CELLS-1:0]         i_visited,
  input  label_t [MAZE_CELLS-1:0]       i_label,
  input  label_t                        i_wave_lbl,
  input  logic                          i_seed,
  output logic [MAZE_CELLS-1:0]         o_new,
  output label_t [MAZE_CELLS-1:0]       o_label_nxt,
  output logic                          o_any_new
);

  for (genvar g = 0; g < MAZE_CELLS; g++) begin : g_cell
    localparam int X = g % MAZE_W;
    localparam int Y = g / MAZE_W;
    logic w_r, w_l, w_d, w_u, w_seed;

    if (X < MAZE_W - 1) begin : g_r
      assign w_r = i_visited[g+1];
    end else begin : g_r0
      assign w_r = 1'b0;
    end
    if (X > 0) begin : g_l
      assign w_l = i_visited[g-1];
    end else begin : g_l0
      assign w_l = 1'b0;
    end
    if (Y < MAZE_H - 1) begin : g_d
      assign w_d = i_visited[g+MAZE_W];
    end else begin : g_d0
      assign w_d = 1'b0;
    end
    if (Y > 0) begin : g_u
      assign w_u = i_visited[g-MAZE_W];
    end else begin : g_u0
      assign w_u = 1'b0;
    end
    // The seed wave marks only the goal cell.
    if (g == MAZE_CELLS - 1) begin : g_goal
      assign w_seed = i_grid[g];
    end else begin : g_ngoal
      assign w_seed = 1'b0;
    end

    assign o_new[g] = i_seed ? w_seed
                             : (i_grid[g] & ~i_visited[g] & (w_r | w_l | w_d | w_u));
    assign o_label_nxt[g] = o_new[g] ? i_wave_lbl : i_label[g];
  end

  assign o_any_new = |o_new;

endmodule

// File: rtl/maze_solver.sv
// 15x15 shortest-path maze solver: serial load, BFS flood from the goal,
// then trace from (0,0). Optional assertions under MAZE_SOLVER_SVA_EN.
//
// state | meaning
// IDLE  | wait for in_valid, capture cell 0
// LOAD  | shift in cells 1..224
// FLOOD | one BFS wave per cycle from the goal
// TRACE | drive path coordinates from start to goal
// FAIL  | one-cycle maze_not_valid pulse
module maze_solver
  import maze_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         maze,
  output logic         out_valid,
  output logic         maze_not_valid,
  output logic [3:0]   out_x,
  output logic [3:0]   out_y
);

  maze_state_e r_state, w_state_n;

  logic [MAZE_CELLS-1:0]   r_grid;
  logic [MAZE_CELLS-1:0]   r_visited;
  label_t [MAZE_CELLS-1:0] r_label;
  logic [7:0]              r_cnt;
  logic [7:0]              r_wave;
  label_t                  r_wave_lbl;
  coord_t                  r_cur_x, r_cur_y;
  logic                    r_out_valid, r_not_valid;
  coord_t                  r_out_x, r_out_y;

  logic                    w_out_valid_n, w_not_valid_n;
  coord_t                  w_out_x_n, w_out_y_n;
  logic [MAZE_CELLS-1:0]   w_new;
  label_t [MAZE_CELLS-1:0] w_label_nxt;
  logic                    w_any_new;

  maze_wave_step u_wave (
    .i_grid      (r_grid),
    .i_visited   (r_visited),
    .i_label     (r_label),
    .i_wave_lbl  (r_wave_lbl),
    .i_seed      (r_wave == 8'd0),
    .o_new       (w_new),
    .o_label_nxt (w_label_nxt),
    .o_any_new   (w_any_new)
  );

  // Trace step: move to a visited neighbour one BFS distance closer.
  logic [7:0] w_idx, w_idx_r, w_idx_d, w_idx_l, w_idx_u;
  label_t     w_tgt;
  logic       w_can_r, w_can_d, w_can_l, w_can_u, w_at_goal;
  coord_t     w_nx, w_ny;

  always_comb begin
    w_idx   = cell_idx(r_cur_x, r_cur_y);
    w_idx_r = (r_cur_x < 4'd14) ? w_idx + 8'd1  : w_idx;
    w_idx_d = (r_cur_y < 4'd14) ? w_idx + 8'd15 : w_idx;
    w_idx_l = (r_cur_x > 4'd0)  ? w_idx - 8'd1  : w_idx;
    w_idx_u = (r_cur_y > 4'd0)  ? w_idx - 8'd15 : w_idx;
    w_tgt   = label_prev(r_label[w_idx]);
    w_can_r = (r_cur_x < 4'd14) && r_visited[w_idx_r] && (r_label[w_idx_r] == w_tgt);
    w_can_d = (r_cur_y < 4'd14) && r_visited[w_idx_d] && (r_label[w_idx_d] == w_tgt);
    w_can_l = (r_cur_x > 4'd0)  && r_visited[w_idx_l] && (r_label[w_idx_l] == w_tgt);
    w_can_u = (r_cur_y > 4'd0)  && r_visited[w_idx_u] && (r_label[w_idx_u] == w_tgt);
    w_at_goal = (r_cur_x == 4'd14) && (r_cur_y == 4'd14);
    w_nx = r_cur_x;
    w_ny = r_cur_y;
    if      (w_can_r) w_nx = r_cur_x + 4'd1;
    else if (w_can_d) w_ny = r_cur_y + 4'd1;
    else if (w_can_l) w_nx = r_cur_x - 4'd1;
    else if (w_can_u) w_ny = r_cur_y - 4'd1;
  end

  always_comb begin
    w_state_n     = r_state;
    w_out_valid_n = 1'b0;
    w_not_valid_n = 1'b0;
    w_out_x_n     = '0;
    w_out_y_n     = '0;
    case (r_state)
      IDLE:  if (in_valid) w_state_n = LOAD;
      LOAD:  if (in_valid && r_cnt == 8'(MAZE_CELLS - 1))
               w_state_n = (!r_grid[0] || !maze) ? FAIL : FLOOD;
      FLOOD: begin
        if (!w_any_new)    w_state_n = FAIL;
        else if (w_new[0]) w_state_n = TRACE;
      end
      TRACE: begin
        w_out_valid_n = 1'b1;
        w_out_x_n     = r_cur_x;
        w_out_y_n     = r_cur_y;
        if (w_at_goal) w_state_n = IDLE;
      end
      FAIL: begin
        w_not_valid_n = 1'b1;
        w_state_n     = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid      <= '0;
      r_visited   <= '0;
      r_label     <= '0;
      r_cnt       <= '0;
      r_wave      <= '0;
      r_wave_lbl  <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_out_valid <= 1'b0;
      r_not_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= w_out_valid_n;
      r_not_valid <= w_not_valid_n;
      r_out_x     <= w_out_x_n;
      r_out_y     <= w_out_y_n;
      case (r_state)
        IDLE: if (in_valid) begin
          r_grid[0]  <= maze;
          r_cnt      <= 8'd1;
          r_visited  <= '0;
          r_label    <= '0;
          r_wave     <= '0;
          r_wave_lbl <= '0;
        end
        LOAD: if (in_valid) begin
          r_grid[r_cnt] <= maze;
          r_cnt         <= r_cnt + 8'd1;
        end
        FLOOD: begin
          r_visited  <= r_visited | w_new;
          r_label    <= w_label_nxt;
          r_wave     <= r_wave + 8'd1;
          r_wave_lbl <= (r_wave_lbl == 2'd2) ? 2'd0 : r_wave_lbl + 2'd1;
          r_cur_x    <= '0;
          r_cur_y    <= '0;
        end
        TRACE: begin
          r_cur_x <= w_nx;
          r_cur_y <= w_ny;
        end
        default: ;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign maze_not_valid = r_not_valid;
  assign out_x          = r_out_x;
  assign out_y          = r_out_y;

`ifdef MAZE_SOLVER_SVA_EN
  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_valid && maze_not_valid));
  a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_x == 4'd0 && out_y == 4'd0));
  a_step: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && $past(out_valid)) |->
      ((out_x == $past(out_x)) && ((out_y == $past(out_y) + 4'd1) || ($past(out_y) == out_y + 4'd1))) ||
      ((out_y == $past(out_y)) && ((out_x == $past(out_x) + 4'd1) || ($past(out_x) == out_x + 4'd1))));
  a_first: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(out_valid) |-> (out_x == 4'd0 && out_y == 4'd0));
  a_last: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(out_valid) |-> ($past(out_x) == 4'd14 && $past(out_y) == 4'd14));
  a_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    maze_not_valid |=> !maze_not_valid);
`endif

endmodule

// File: tb/tb_maze_solver.sv
// Directed, table-driven bench for maze_solver with hand-computed latencies and paths.
module tb_maze_solver;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, maze;
  logic       out_valid, maze_not_valid;
  logic [3:0] out_x, out_y;

  always #5 clk = ~clk;

  maze_solver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .maze           (maze),
    .out_valid      (out_valid),
    .maze_not_valid (maze_not_valid),
    .out_x          (out_x),
    .out_y          (out_y)
  );

  int n_err = 0;
  int n_chk = 0;
  int ex_q[$];
  int ey_q[$];

  typedef struct {
    string name;
    int    maze_kind;
    bit    exp_fail;
    int    exp_lat;   // edges after E0 to first out_valid or to the pulse
    int    path_kind; // 0 = row 0 then column 14, 1 = serpentine, -1 = none
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [224:0] mk_maze(input int kind);
    logic [224:0] m;
    bit o;
    m = '0;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 15; x++) begin
        case (kind)
          1:       o = !(x == 0 && y == 0);
          2:       o = !(x == 14 && y == 14);
          3:       o = (x != 7);
          4:       o = (x == 0 || x == 14 || y == 0 || y == 14);
          5:       o = ((y % 2 == 0) && y <= 12) ||
                       ((y % 4 == 1) && x == 14) ||
                       ((y % 4 == 3) && x == 0) ||
                       (y == 14 && x == 14);
          default: o = 1'b1;
        endcase
        m[y*15+x] = o;
      end
    return m;
  endfunction

  task automatic build_path(input int kind);
    ex_q.delete();
    ey_q.delete();
    if (kind == 0) begin
      for (int x = 0; x < 15; x++) begin ex_q.push_back(x); ey_q.push_back(0); end
      for (int y = 1; y < 15; y++) begin ex_q.push_back(14); ey_q.push_back(y); end
    end else if (kind == 1) begin
      for (int r = 0; r < 7; r++) begin
        for (int i = 0; i < 15; i++) begin
          ex_q.push_back((r % 2 == 0) ? i : 14 - i);
          ey_q.push_back(2 * r);
        end
        ex_q.push_back((r % 2 == 0) ? 14 : 0);
        ey_q.push_back(2 * r + 1);
      end
      ex_q.push_back(14);
      ey_q.push_back(14);
    end
  endtask

  task automatic send(input logic [224:0] bits);
    for (int n = 0; n < 225; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      maze     = bits[n];
    end
    @(negedge clk);
    in_valid = 1'b0;
    maze     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int k, first, last, nvalid, npulse, pulse_k, idle_bad, both, quiet;
    bit done;
    k = 0; first = -1; last = -1; nvalid = 0; npulse = 0; pulse_k = -1;
    idle_bad = 0; both = 0; quiet = 0; done = 1'b0;
    build_path(v.path_kind);
    send(mk_maze(v.maze_kind));
    while (k < 3000 && !(done && quiet >= 4)) begin
      @(negedge clk);
      k++;
      if (out_valid) begin
        if (first < 0) first = k;
        last = k;
        if (nvalid < ex_q.size()) begin
          chk($sformatf("%s x[%0d]", v.name, nvalid), int'(out_x), ex_q[nvalid]);
          chk($sformatf("%s y[%0d]", v.name, nvalid), int'(out_y), ey_q[nvalid]);
        end
        nvalid++;
      end else if (out_x != 4'd0 || out_y != 4'd0) begin
        idle_bad++;
      end
      if (maze_not_valid) begin
        npulse++;
        if (pulse_k < 0) pulse_k = k;
        if (out_valid) both++;
      end
      if (npulse > 0 || (nvalid > 0 && !out_valid)) done = 1'b1;
      if (done) quiet++;
    end
    chk({v.name, " timeout"}, int'(done), 1);
    chk({v.name, " idle_coords_nonzero"}, idle_bad, 0);
    chk({v.name, " valid_and_fail_together"}, both, 0);
    if (v.exp_fail) begin
      chk({v.name, " pulse_count"}, npulse, 1);
      chk({v.name, " pulse_latency"}, pulse_k, v.exp_lat);
      chk({v.name, " valid_count"}, nvalid, 0);
    end else begin
      chk({v.name, " pulse_count"}, npulse, 0);
      chk({v.name, " first_latency"}, first, v.exp_lat);
      chk({v.name, " path_len"}, nvalid, ex_q.size());
      chk({v.name, " gap_free_span"}, last - first + 1, ex_q.size());
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " out_valid"}, int'(out_valid), 0);
    chk({name, " maze_not_valid"}, int'(maze_not_valid), 0);
    chk({name, " out_x"}, int'(out_x), 0);
    chk({name, " out_y"}, int'(out_y), 0);
  endtask

  task automatic chk_quiet(input string name, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid || maze_not_valid) act++;
    end
    chk(name, act, 0);
  endtask

  initial begin
    int w;
    tbl[0] = '{"all_open",   0, 1'b0,  30, 0};
    tbl[1] = '{"start_wall", 1, 1'b1,   1, -1};
    tbl[2] = '{"goal_wall",  2, 1'b1,   1, -1};
    tbl[3] = '{"col7_wall",  3, 1'b1,  23, -1};
    tbl[4] = '{"perimeter",  4, 1'b0,  30, 0};
    tbl[5] = '{"serpentine", 5, 1'b0, 114, 1};

    rst_n = 1'b0; in_valid = 1'b0; maze = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of the flood, then the same maze again.
    send(mk_maze(0));
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_flood_reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_quiet("after_flood_reset_quiet", 40);
    run_vec(tbl[0]);
    repeat (3) @(negedge clk);

    // Reset while a path is being driven.
    send(mk_maze(0));
    w = 0;
    while (!out_valid && w < 200) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    chk("pre_trace_reset out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_trace_reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_quiet("after_trace_reset_quiet", 40);
    run_vec(tbl[4]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/maze_solver.md
# maze_solver

- Synthesizable 15x15 maze solver.
- Accepts a maze serially, one cell per cycle, and returns the shortest path from start (0,0) to goal (14,14) as a stream of coordinates.
- If no path exists, it reports the maze as invalid instead.
- It is the design-under-test end of the maze interface driven and checked by the team's PATTERN bench.

## Interface
- Parameters: none. Dimensions are fixed by `maze_pkg`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: high for exactly 225 consecutive cycles while `maze` carries cells.
- `maze` input 1: cell value; 1 = open, 0 = wall. Row-major order, x fastest: bit n is (x = n%15, y = n/15).
- `out_valid` output 1: high while `out_x`/`out_y` carry a path coordinate.
- `maze_not_valid` output 1: one-cycle pulse when no path exists.
- `out_x` output 4: path x coordinate.
- `out_y` output 4: path y coordinate.

## Operation
- FSM states: IDLE, LOAD, FLOOD, TRACE, FAIL.
- **IDLE**
  - `in_valid`=1 → capture bit 0 and go to LOAD.
  - `in_valid` is ignored in every state other than IDLE and LOAD.
- **LOAD**
  - Shift one bit per cycle into the 225-bit grid; a cell counter (0..224) selects the slot.
  - After bit 224, go to FLOOD.
  - If start or goal is a wall, go to FAIL instead.
- **FLOOD** (breadth-first wavefront from the goal)
  - Each cell holds a visited bit and a 2-bit label = BFS distance mod 3.
  - Wave 0 marks the goal, label 0.
  - Each wave marks every open, unvisited cell 4-adjacent to any visited cell, label = wave mod 3.
  - A wave counter tracks the current distance, 8 bits, max 224.
  - Start marked → TRACE.
  - A wave marks no new cell → FAIL.
- **TRACE**
  - Cursor starts at (0,0) and drives it out, then steps once per cycle.
  - Each step moves to the neighbour whose label = (cursor label − 1) mod 3.
  - Tie-break priority: right (x+1), down (y+1), left (x−1), up (y−1).
  - After (14,14) has been driven, go to IDLE.
  - Path length = start distance D + 1 coordinates, driven on consecutive cycles with no gaps.
- **FAIL**: pulse `maze_not_valid` for one cycle, then go to IDLE.
- Output rules:
  - `out_valid` and `maze_not_valid` are never high together.
  - `out_x`/`out_y` are 0 whenever `out_valid`=0.
  - All outputs are registered.

## Timing
- Reset value of every output is 0.
- Reset also clears the grid, labels, counters and the FSM (to IDLE), immediately and at any point, including mid-LOAD, mid-FLOOD and mid-TRACE.
- Call E0 the edge that captures bit 224.
- Wave 0 is on edge E0+1; wave k is on edge E0+1+k.
- First `out_valid` cycle starts at edge E0+D+2.
- Last `out_valid` cycle starts at edge E0+2D+2.
- Wall at start or goal: `maze_not_valid` pulse at E0+1.
- Unreachable goal: pulse on the edge after the first empty wave.
- Worst-case latency is under 460 cycles from E0 to end of output, well inside the bench's 3000-cycle limit.

## Configuration
- `MAZE_SOLVER_SVA_EN` defined: compile in concurrent assertions:
  - `out_valid` and `maze_not_valid` are mutually exclusive.
  - Outputs are zero when idle.
  - Consecutive path coordinates are Manhattan distance 1 apart.
  - The first path coordinate is (0,0); the last is (14,14).
  - `maze_not_valid` is high for at most one cycle.
- `MAZE_SOLVER_SVA_EN` undefined: no assertions; RTL behaviour is identical.

## Structure
- `maze_pkg` holds:
  - constants `MAZE_W`=15, `MAZE_H`=15, `MAZE_CELLS`=225;
  - `typedef logic [3:0] coord_t`;
  - `typedef logic [1:0] label_t`;
  - the FSM state enum `maze_state_e`.
- Sub-module `maze_wave_step`: combinational next-wave computation over the whole array.
  - Inputs: grid, visited, wave label.
  - Outputs: new-mark vector and any-new flag.
- The top level holds the FSM, the storage and the trace cursor.

## Test plan
- **All-open maze**: D=28; 29 `out_valid` cycles.
  - Sequence (0,0),(1,0)…(14,0),(14,1)…(14,14).
  - First `out_valid` at E0+30.
- **Bit 0 = 0 (start walled)**: single `maze_not_valid` pulse at E0+1; `out_valid` never asserts.
- **Column x=7 all walls, rest open**: `maze_not_valid` pulse after the flood exhausts; no `out_valid`.
- **Only the perimeter open**: two equal 28-step routes; the right-first tie-break yields the row-0 then column-14 path, 29 coordinates.
- **Single serpentine corridor** (rows alternate open, joined at alternating ends): output exactly follows the corridor cells in order, with no gaps.
- **`rst_n` low mid-FLOOD**: all outputs 0 immediately. Re-sending the all-open maze then produces the correct 29-coordinate path.
